alu_arbiter: RTL
================

# alu_arbiter

Two-port arbiter and sequencer that shares the single registered `arithmetic_logic_unit` between two requesters, e.g. the execute stage and the address-calculation path. It accepts one operation at a time through a valid/ready handshake and picks between simultaneous requesters round-robin. It holds the ALU operands stable for the ALU's fixed latency, then captures the result and returns it, with zero, overflow and error flags, to the requester that issued the operation.

## Interface
- `WIDTH`, 32, operand/result width.
- `ALU_LATENCY`, 1, edges from operand launch to valid `alu_result`/`alu_overflow`; legal range 1..15.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  2  bit i: requester i presents an operation.
- `req_ready`  out  2  bit i: operation of requester i accepted this cycle (one-hot or zero).
- `req_op`  in  2*3  requester i opcode at `[3*i +: 3]`.
- `req_a`  in  2*WIDTH  requester i operand A at `[WIDTH*i +: WIDTH]`.
- `req_b`  in  2*WIDTH  requester i operand B, same packing.
- `rsp_valid`  out  2  one-hot, one-cycle pulse to the originating requester; no backpressure.
- `rsp_result`  out  WIDTH  captured result, valid while any `rsp_valid` bit is high.
- `rsp_zero`  out  1  `rsp_result == 0`, computed by this block at capture.
- `rsp_overflow`  out  1  `alu_overflow` captured with the result.
- `rsp_err`  out  1  illegal opcode; result and flags forced to 0.
- `busy`  out  1  state != IDLE.
- `alu_op`  out  3  ALU opcode, registered.
- `alu_a`, `alu_b`  out  WIDTH  ALU operands, registered.
- `alu_result`  in  WIDTH  ALU result.
- `alu_overflow`  in  1  ALU overflow flag.

## Operation
- Legal opcodes are 000 AND, 001 OR, 010 ADD, 110 SUB, 100 SHL1 and 101 SHR1. Opcodes 011 and 111 are illegal.
- States are IDLE, EXEC and RESP.
- IDLE:
  - `req_ready = grant`, a combinational function of `req_valid` and `last_grant`.
  - When exactly one request is valid, that requester is granted.
  - When both are valid, the requester with index != `last_grant` is granted.
- Handshake occurs when `req_valid[i] & req_ready[i]`. At that edge:
  - Latch the tag (i) and set `last_grant <= i`.
  - Legal op: load `alu_op`/`alu_a`/`alu_b` from lane i, set `cnt <= ALU_LATENCY-1`, go to EXEC.
  - Illegal op: do not touch the ALU registers, set `err <= 1`, go to RESP.
- EXEC:
  - `req_ready = 0`; the ALU outputs hold their values.
  - If `cnt != 0`, decrement `cnt`.
  - If `cnt == 0`, capture `alu_result`, `alu_overflow` and zero-detect into the `rsp_*` registers, then go to RESP.
- RESP:
  - `rsp_valid[tag] = 1` for exactly one cycle; `req_ready = 0`.
  - Next edge: go to IDLE and clear `err`.
- `rsp_result`/flags hold their last value outside the RESP pulse.
- `last_grant` updates only on a handshake. A requester dropping `req_valid` before handshake is legal and grants nothing.
- Only one operation is outstanding at any time.

## Timing
- Reset values: state IDLE, `req_ready` 0 during the `rst` cycle, `rsp_valid` 0, `rsp_result` 0, `rsp_zero`/`rsp_overflow`/`rsp_err` 0, `alu_op` 000, `alu_a`/`alu_b` 0, `busy` 0, `last_grant` 1 (requester 0 wins the first tie), `cnt` 0.
- Legal op:
  - Handshake at edge E0; ALU sees new operands after E0.
  - Capture at edge E(ALU_LATENCY).
  - `rsp_valid` is high during the cycle following E(ALU_LATENCY).
  - State returns to IDLE at E(ALU_LATENCY+1).
  - The earliest next handshake is at edge E(ALU_LATENCY+2) if the request is already valid.
  - Throughput is one op per ALU_LATENCY+2 cycles.
- Illegal op: `rsp_valid` is high the cycle after E0; next handshake at E2 earliest.
- Reset mid-operation: `rst` at any edge forces IDLE and the reset values. The in-flight op is dropped with no response, and `rsp_valid` is 0 the following cycle.
- Width: ALU ops are computed by the ALU at WIDTH. This block performs no arithmetic except zero-detect and the 4-bit `cnt`.

## Test plan
- Single ADD, ALU_LATENCY=1: lane0 op=010, a=5, b=7 → `req_ready` = 01 at handshake; 1 cycle later `rsp_valid` = 01, `rsp_result` = 12, zero=0, ovf=0, err=0.
- Tie: both lanes valid continuously after reset, lane0 SUB 9-9, lane1 OR 0xF0|0x0F → grants alternate 0,1,0,1. Lane0 gets result 0 with zero=1; lane1 gets 0xFF.
- Illegal op: lane1 op=111, a=1, b=2 → `rsp_valid` = 10 one cycle after handshake, `rsp_err` = 1, result 0, `alu_op`/`alu_a`/`alu_b` unchanged.
- ALU_LATENCY=3: lane0 op=100, a=0x80000001 → `alu_*` stable for 3 cycles, `rsp_result` = 0x00000002; `req_ready` stays 0 while `busy` = 1.
- Overflow passthrough: ALU model asserts `alu_overflow` on 0xFFFFFFFF+1 → `rsp_overflow` = 1, `rsp_zero` = 1.
- Reset in EXEC (ALU_LATENCY=3, `rst` one cycle after handshake) → no `rsp_valid` pulse, all outputs at reset values. The next tie is granted to lane 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one registered ALU between two requesters.
// Holds the operands for the ALU latency, then returns the result to the requester that issued the operation.
module alu_arbiter #(
    parameter int WIDTH       = 32,
    parameter int ALU_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [5:0]         req_op,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    output logic [1:0]         rsp_valid,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_zero,
    output logic               rsp_overflow,
    output logic               rsp_err,
    output logic               busy,
    output logic [2:0]         alu_op,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_overflow
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(ALU_LATENCY - 1);

    state_t     state;
    logic       last_grant;
    logic       tag;
    logic       err;
    logic [3:0] cnt;
    logic [1:0] grant;
    logic       hs;
    logic       sel;
    logic [2:0] sel_op;
    logic       sel_legal;

    // On a tie, the requester that did not win the last handshake goes first.
    always_comb begin
        grant = 2'b00;
        if (state == IDLE && !rst) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign hs        = |(req_valid & grant);
    assign sel       = grant[1];
    assign sel_op    = sel ? req_op[5:3] : req_op[2:0];
    assign sel_legal = (sel_op[1:0] != 2'b11);
    assign busy      = (state != IDLE);
    assign rsp_err   = err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            tag          <= 1'b0;
            err          <= 1'b0;
            cnt          <= 4'd0;
            rsp_valid    <= 2'b00;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            alu_op       <= 3'b000;
            alu_a        <= '0;
            alu_b        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        tag        <= sel;
                        last_grant <= sel;
                        if (sel_legal) begin
                            alu_op <= sel_op;
                            alu_a  <= sel ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                            alu_b  <= sel ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                            cnt    <= CNT_INIT;
                            state  <= EXEC;
                        end else begin
                            // Illegal opcodes never reach the ALU; answer at once with an error.
                            err          <= 1'b1;
                            rsp_result   <= '0;
                            rsp_zero     <= 1'b0;
                            rsp_overflow <= 1'b0;
                            rsp_valid    <= sel ? 2'b10 : 2'b01;
                            state        <= RESP;
                        end
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_result   <= alu_result;
                        rsp_zero     <= (alu_result == '0);
                        rsp_overflow <= alu_overflow;
                        rsp_valid    <= tag ? 2'b10 : 2'b01;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 2'b00;
                    err       <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
